// File: rtl/wfg_cfg_seq.sv
// Table-driven Wishbone write sequencer: reads (address, data) pairs from a
// single-port SRAM and issues one Wishbone write per entry.
module wfg_cfg_seq #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [8:0]    count_i,
  output logic          csb_o,
  output logic [AW-1:0] addr_o,
  input  logic [31:0]   dout_i,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [31:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic          wbm_ack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [8:0]    done_cnt_o,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADR  = 3'd1,
    S_RD_DAT  = 3'd2,
    S_LAT_DAT = 3'd3,
    S_WB      = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [8:0]    r_remaining;
  logic [8:0]    r_done_cnt;
  logic [31:0]   r_wb_adr, r_wb_dat;
  logic [7:0]    r_wait;
  logic          r_done, r_err;

  logic          w_accept, w_ack, w_tmo, w_done, w_wb_act, w_csb;
  logic [AW-1:0] w_addr;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Wishbone handshake: cyc/stb/we stay high with stable adr/dat until ack is
  // sampled high on a rising edge; that edge completes the transfer.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ack    = 1'b0;
    w_tmo    = 1'b0;
    w_done   = 1'b0;
    w_wb_act = 1'b0;
    w_csb    = 1'b1;
    w_addr   = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept = 1'b1;
          if (count_i != 9'd0) w_next = S_RD_ADR;
          else                 w_done = 1'b1;
        end
      end
      S_RD_ADR: begin
        w_csb  = 1'b0;
        w_addr = r_ptr;
        w_next = S_RD_DAT;
      end
      S_RD_DAT: begin
        w_csb  = 1'b0;
        w_addr = r_ptr + AW'(1);
        w_next = S_LAT_DAT;
      end
      S_LAT_DAT: begin
        if (r_wb_adr == 32'hFFFF_FFFF) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_wb_act = 1'b1;
        if (wbm_ack_i) begin
          w_ack = 1'b1;
          if (r_remaining == 9'd1) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else begin
            w_next = S_RD_ADR;
          end
        end else if (r_wait == 8'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over a same-cycle ack or timeout; that ack is not counted.
    if (r_state != S_IDLE && abort_i) begin
      w_next = S_IDLE;
      w_done = 1'b1;
      w_ack  = 1'b0;
      w_tmo  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_done_cnt  <= '0;
      r_wb_adr    <= '0;
      r_wb_dat    <= '0;
      r_wait      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_accept) begin
        r_ptr       <= base_addr_i;
        r_remaining <= count_i;
        r_done_cnt  <= '0;
        r_err       <= 1'b0;
      end
      if (r_state == S_RD_DAT)  r_wb_adr <= dout_i;
      if (r_state == S_LAT_DAT) r_wb_dat <= dout_i;
      // Wait counter is zero on every WB entry since WB is only entered from LAT_DAT.
      if (r_state == S_WB) r_wait <= r_wait + 8'd1;
      else                 r_wait <= '0;
      if (w_ack) begin
        r_done_cnt  <= r_done_cnt + 9'd1;
        r_ptr       <= r_ptr + AW'(2);
        r_remaining <= r_remaining - 9'd1;
      end
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign csb_o       = w_csb;
  assign addr_o      = w_addr;
  assign wbm_cyc_o   = w_wb_act;
  assign wbm_stb_o   = w_wb_act;
  assign wbm_we_o    = w_wb_act;
  assign wbm_adr_o   = r_wb_adr;
  assign wbm_dat_o   = r_wb_dat;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign done_cnt_o  = r_done_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wfg_cfg_seq.sv
// Directed bench for wfg_cfg_seq with an SRAM model, a Wishbone slave that
// acks one cycle after stb, and monitors for writes, reads and done pulses.
module tb_wfg_cfg_seq;
  localparam int AW  = 10;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] base = '0;
  logic [8:0]    count = '0;
  logic          csb;
  logic [AW-1:0] addr;
  logic [31:0]   dout = '0;
  logic          cyc, stb, we;
  logic [31:0]   wadr, wdat;
  logic          ack = 1'b0;
  logic          busy, done, err;
  logic [8:0]    dcnt;
  logic [2:0]    st;
  logic          ack_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  wfg_cfg_seq #(.AW(AW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base), .count_i(count), .csb_o(csb), .addr_o(addr),
    .dout_i(dout), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_adr_o(wadr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .busy_o(busy),
    .done_o(done), .err_o(err), .done_cnt_o(dcnt), .dbg_state_o(st)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) if (!csb) dout <= sram[addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= ack_en && cyc && stb && !ack;
  end

  int unsigned   n_done = 0;
  int unsigned   n_stb  = 0;
  logic [31:0]   wr_adr_q[$];
  logic [31:0]   wr_dat_q[$];
  logic [AW-1:0] rd_q[$];
  always @(posedge clk) begin
    if (done) n_done++;
    if (stb)  n_stb++;
    if (cyc && stb && ack && !abort_i) begin
      wr_adr_q.push_back(wadr);
      wr_dat_q.push_back(wdat);
    end
    if (!csb) rd_q.push_back(addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [8:0] c);
    base    = b;
    count   = c;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 300) begin
      tick();
      i++;
    end
    check(tag, 64'(busy), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, r0, s0, i;
    for (int k = 0; k < (1 << AW); k++) sram[k] = 32'd0;

    // Reset state, checked while reset is held
    #12;
    check("rst_csb",   64'(csb),  64'd1);
    check("rst_cyc",   64'(cyc),  64'd0);
    check("rst_addr",  64'(addr), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_err",   64'(err),  64'd0);
    check("rst_dcnt",  64'(dcnt), 64'd0);
    check("rst_wadr",  64'(wadr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Two plain entries; first stb appears in cycle k+4
    sram[0] = 32'h14; sram[1] = 32'h1; sram[2] = 32'h24; sram[3] = 32'h5;
    ack_en = 1'b1;
    d0 = n_done; w0 = wr_adr_q.size(); r0 = rd_q.size();
    do_start(10'd0, 9'd2);
    check("lat_state_rdadr", 64'(st),  64'd1);
    check("lat_stb_k1",      64'(stb), 64'd0);
    tick(); check("lat_stb_k2", 64'(stb), 64'd0);
    tick(); check("lat_stb_k3", 64'(stb), 64'd0);
    tick(); check("lat_stb_k4", 64'(stb), 64'd1);
    check("t1_we",     64'(we),   64'd1);
    check("t1_wadr0",  64'(wadr), 64'h14);
    check("t1_wdat0",  64'(wdat), 64'h1);
    wait_idle("t1_idle");
    check("t1_nwr",    64'(wr_adr_q.size() - w0), 64'd2);
    check("t1_adr1",   64'(wr_adr_q[w0+1]), 64'h24);
    check("t1_dat1",   64'(wr_dat_q[w0+1]), 64'h5);
    check("t1_ndone",  64'(n_done - d0), 64'd1);
    check("t1_dcnt",   64'(dcnt), 64'd2);
    check("t1_err",    64'(err),  64'd0);
    check("t1_nrd",    64'(rd_q.size() - r0), 64'd4);

    // End marker in entry 1 stops after one write
    sram[10] = 32'h30; sram[11] = 32'h7; sram[12] = 32'hFFFF_FFFF; sram[13] = 32'h9;
    d0 = n_done; w0 = wr_adr_q.size();
    do_start(10'd10, 9'd3);
    wait_idle("t2_idle");
    check("t2_nwr",   64'(wr_adr_q.size() - w0), 64'd1);
    check("t2_adr0",  64'(wr_adr_q[w0]), 64'h30);
    check("t2_dat0",  64'(wr_dat_q[w0]), 64'h7);
    check("t2_ndone", 64'(n_done - d0), 64'd1);
    check("t2_dcnt",  64'(dcnt), 64'd1);

    // Timeout: slave never acks
    ack_en = 1'b0;
    sram[20] = 32'h40; sram[21] = 32'hAA;
    d0 = n_done; s0 = n_stb;
    do_start(10'd20, 9'd1);
    wait_idle("t3_idle");
    check("t3_nstb",  64'(n_stb - s0), 64'd8);
    check("t3_err",   64'(err),  64'd1);
    check("t3_ndone", 64'(n_done - d0), 64'd1);
    check("t3_dcnt",  64'(dcnt), 64'd0);
    // Zero-count start clears err and pulses done without going busy
    ack_en = 1'b1;
    do_start(10'd0, 9'd0);
    check("t3_err_clr", 64'(err),  64'd0);
    check("t3_zdone",   64'(done), 64'd1);
    check("t3_zbusy",   64'(busy), 64'd0);
    tick();
    check("t3_zdone_1cyc", 64'(done), 64'd0);

    // Pointer wrap at the top of the address space
    sram[1022] = 32'h50; sram[1023] = 32'h11; sram[0] = 32'h60; sram[1] = 32'h22;
    r0 = rd_q.size(); w0 = wr_adr_q.size();
    do_start(10'd1022, 9'd2);
    wait_idle("t4_idle");
    check("t4_nrd", 64'(rd_q.size() - r0), 64'd4);
    check("t4_rd0", 64'(rd_q[r0]),   64'd1022);
    check("t4_rd1", 64'(rd_q[r0+1]), 64'd1023);
    check("t4_rd2", 64'(rd_q[r0+2]), 64'd0);
    check("t4_rd3", 64'(rd_q[r0+3]), 64'd1);
    check("t4_adr1", 64'(wr_adr_q[w0+1]), 64'h60);
    check("t4_dat1", 64'(wr_dat_q[w0+1]), 64'h22);

    // Abort coincident with the ack of entry 2
    sram[30] = 32'h70; sram[31] = 32'h1; sram[32] = 32'h74; sram[33] = 32'h2;
    d0 = n_done; w0 = wr_adr_q.size();
    do_start(10'd30, 9'd2);
    i = 0;
    while (!(ack && dcnt == 9'd1) && i < 100) begin
      tick();
      i++;
    end
    check("t5_found_ack2", 64'(ack && dcnt == 9'd1), 64'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_cyc",  64'(cyc),  64'd0);
    check("t5_csb",  64'(csb),  64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_dcnt", 64'(dcnt), 64'd1);
    tick(); tick();
    check("t5_ndone", 64'(n_done - d0), 64'd1);
    check("t5_nwr",   64'(wr_adr_q.size() - w0), 64'd1);

    // Reset mid-WB: outputs fall without a clock edge, no done pulse
    ack_en = 1'b0;
    sram[40] = 32'h80; sram[41] = 32'h3;
    do_start(10'd40, 9'd1);
    tick(); tick(); tick();
    check("t6_stb_before", 64'(stb), 64'd1);
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    check("t6_cyc",  64'(cyc),  64'd0);
    check("t6_stb",  64'(stb),  64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_wadr", 64'(wadr), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_ndone_rst", 64'(n_done - d0), 64'd0);
    check("t6_idle_wait", 64'(busy), 64'd0);
    ack_en = 1'b1;
    w0 = wr_adr_q.size();
    do_start(10'd40, 9'd1);
    wait_idle("t6_idle");
    check("t6_nwr", 64'(wr_adr_q.size() - w0), 64'd1);
    check("t6_adr", 64'(wr_adr_q[w0]), 64'h80);
    check("t6_dat", 64'(wr_dat_q[w0]), 64'h3);
    check("t6_dcnt", 64'(dcnt), 64'd1);
    check("t6_err",  64'(err),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
